// File: rtl/mem_responder.sv
// Memory responder: loads IMEM/DMEM from a loader stream, then serves a CPU with 1-cycle reads until a halt write.
// Latency: ID and DD read data are registered (1 cycle). Backpressure: LD_READY is high only while loading.
module mem_responder #(
    parameter int          DEPTH     = 128,
    parameter logic [15:0] HALT_ADDR = 16'h0000,
    parameter logic [15:0] HALT_DATA = 16'h0004
) (
    input  logic        CK,
    input  logic        RST,
    input  logic [15:0] IA,
    output logic [15:0] ID,
    input  logic [15:0] DA,
    inout  wire  [15:0] DD,
    input  logic        RW,
    input  logic        LD_VALID,
    output logic        LD_READY,
    input  logic        LD_SEL,
    input  logic [15:0] LD_DATA,
    input  logic        LD_DONE,
    output logic        CPU_HOLD,
    output logic        HALT
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] iptr_q, iptr_d;
    logic [AW-1:0] dptr_q, dptr_d;
    logic [15:0]   id_q, id_d;
    logic [15:0]   rd_q, rd_d;
    logic          halt_q, halt_d;
    logic          hold_q, hold_d;
    logic          ready_q, ready_d;

    logic [15:0]   imem [DEPTH];
    logic [15:0]   dmem [DEPTH];

    logic          imem_we;
    logic          dmem_we;
    logic [AW-1:0] dmem_wa;
    logic [15:0]   dmem_wd;

    logic [AW-1:0] ia_idx, da_idx;
    logic          ia_ok, da_ok;

    // Addresses with any bit set above the index range fall outside the memory.
    assign ia_idx = IA[AW-1:0];
    assign da_idx = DA[AW-1:0];
    assign ia_ok  = ((IA >> AW) == 16'h0000);
    assign da_ok  = ((DA >> AW) == 16'h0000);

    always_comb begin
        state_d = state_q;
        iptr_d  = iptr_q;
        dptr_d  = dptr_q;
        id_d    = id_q;
        rd_d    = rd_q;
        halt_d  = halt_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        imem_we = 1'b0;
        dmem_we = 1'b0;
        dmem_wa = dptr_q;
        dmem_wd = LD_DATA;
        case (state_q)
            ST_LOAD: begin
                id_d = '0;
                if (LD_VALID) begin
                    if (LD_SEL) begin
                        dmem_we = 1'b1;
                        dptr_d  = (dptr_q == PTR_MAX) ? '0 : dptr_q + 1'b1;
                    end else begin
                        imem_we = 1'b1;
                        iptr_d  = (iptr_q == PTR_MAX) ? '0 : iptr_q + 1'b1;
                    end
                end
                if (LD_DONE) begin
                    state_d = ST_RUN;
                    hold_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end
            ST_RUN, ST_DONE: begin
                id_d = ia_ok ? imem[ia_idx] : '0;
                if (RW) begin
                    rd_d = da_ok ? dmem[da_idx] : '0;
                end else if (state_q == ST_RUN) begin
                    if (da_ok) begin
                        dmem_we = 1'b1;
                        dmem_wa = da_idx;
                        dmem_wd = DD;
                    end
                    if (DA == HALT_ADDR && DD == HALT_DATA) begin
                        halt_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                hold_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_LOAD;
            iptr_q  <= '0;
            dptr_q  <= '0;
            id_q    <= '0;
            rd_q    <= '0;
            halt_q  <= 1'b0;
            hold_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            iptr_q  <= iptr_d;
            dptr_q  <= dptr_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            halt_q  <= halt_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
        end
    end

    // Memory contents deliberately survive reset so a reloaded run can reuse them.
    always_ff @(posedge CK) begin
        if (imem_we) imem[iptr_q] <= LD_DATA;
        if (dmem_we) dmem[dmem_wa] <= dmem_wd;
    end

    assign DD       = (RW && state_q != ST_LOAD) ? rd_q : 16'hzzzz;
    assign ID       = id_q;
    assign HALT     = halt_q;
    assign CPU_HOLD = hold_q;
    assign LD_READY = ready_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning words in each of IMEM and DMEM; address index = low log2(DEPTH) bits.
REQ-002 SHALL have parameter HALT_ADDR, default 16'h0000, meaning the data address watched for the completion write.
REQ-003 SHALL have parameter HALT_DATA, default 16'h0004, meaning the data value that marks completion.
REQ-004 SHALL have port CK  in  1  single clock, rising edge active.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IA  in  16  instruction address from CPU.
REQ-007 SHALL have port ID  out  16  instruction word to CPU.
REQ-008 SHALL have port DA  in  16  data address from CPU.
REQ-009 SHALL have port DD  inout  16  bidirectional data bus.
REQ-010 SHALL have port RW  in  1  1 = CPU read, 0 = CPU write.
REQ-011 SHALL have port LD_VALID  in  1  loader word valid.
REQ-012 SHALL have port LD_READY  out  1  responder accepts loader word.
REQ-013 SHALL have port LD_SEL  in  1  loader target, 0 = IMEM, 1 = DMEM.
REQ-014 SHALL have port LD_DATA  in  16  loader word.
REQ-015 SHALL have port LD_DONE  in  1  loader finished, start CPU.
REQ-016 SHALL have port CPU_HOLD  out  1  active-high reset to CPU.
REQ-017 SHALL have port HALT  out  1  completion flag, sticky.

Function
REQ-018 SHALL implement FSM states LOAD, RUN, DONE; LOAD -> RUN on LD_DONE=1; RUN -> DONE on halt-write match; DONE exits only via reset.
REQ-019 In LOAD, SHALL assert LD_READY=1 and CPU_HOLD=1; in RUN and DONE, LD_READY=0 and CPU_HOLD=0 (registered, changing on the edge that changes state).
REQ-020 In LOAD, on each edge with LD_VALID=1, SHALL write LD_DATA to the memory selected by LD_SEL at that memory's load pointer, then increment that pointer.
REQ-021 SHALL keep separate IMEM and DMEM load pointers; each wraps DEPTH-1 -> 0, silently overwriting.
REQ-022 If LD_VALID and LD_DONE coincide, SHALL write the word and enter RUN on the same edge.
REQ-023 In RUN and DONE, SHALL register ID <= IMEM[IA index] every edge (1-cycle latency); in LOAD, ID SHALL be 0.
REQ-024 In RUN and DONE with RW=1, SHALL register read data <= DMEM[DA index] every edge (1-cycle latency) and drive it onto DD.
REQ-025 SHALL drive DD only when RW=1 and state != LOAD; otherwise DD SHALL be high-Z (combinational enable).
REQ-026 In RUN with RW=0, SHALL write DD to DMEM[DA index] on the edge.
REQ-027 If DA[15:log2(DEPTH)] != 0, reads SHALL return 0 and writes SHALL be ignored; the same rule applies to IA for ID.
REQ-028 In RUN, a write with DA=HALT_ADDR and DD=HALT_DATA SHALL be stored, set HALT=1 and enter DONE on the same edge.
REQ-029 In DONE, SHALL ignore CPU writes and continue serving reads and ID.
REQ-030 In LOAD, SHALL ignore CPU reads and writes.

Reset
REQ-031 RST=0 SHALL immediately set state=LOAD, both load pointers=0, ID=0, read register=0, HALT=0, CPU_HOLD=1 and LD_READY=1; memory contents are not cleared.
REQ-032 Reset asserted in any state, mid-load or mid-run, SHALL behave as REQ-031, and contents written before reset SHALL be retained.

Verification
REQ-033 Load IMEM with 0xC000, 0xC101, then LD_DONE; IA=1 -> ID=0xC101 one edge later; CPU_HOLD falls on the LD_DONE edge.
REQ-034 Load 3 DMEM words 0x1111, 0x2222, 0x3333, then run with RW=1, DA=2 -> DD=0x3333 after one edge; with RW=0, DD is Z.
REQ-035 Load DEPTH+1 IMEM words with values 0..DEPTH -> IMEM[0]=DEPTH and IMEM[1]=1.
REQ-036 In RUN, write DA=5, DD=0x00AA, then read DA=5 -> 0x00AA; write DA=0x0080 -> no DMEM change, and reading DA=0x0080 -> 0.
REQ-037 In RUN, write DA=0, DD=0x0004 -> HALT=1 on that edge; a later write DA=5, DD=0x0055 -> DMEM[5] stays 0x00AA.
REQ-038 Assert RST mid-run -> HALT=0, CPU_HOLD=1, ID=0 immediately; after LD_DONE, IMEM and DMEM contents are unchanged.
